xor_descrambler: RTL

- Self-synchronizing descrambler. It is the receive-side inverse of the team's XOR-based scrambler, polynomial x^7 + x^4 + 1.
- Accepts DATA_W scrambled bits per beat on a valid/ready input stream and emits descrambled bits on a registered valid/ready output stream.
- Sits between the serial-to-parallel front end and the frame parser.
- Reports lock once its 7-bit history holds real line data.

---
 rtl/xor_descrambler.sv | 100 ++++++++++
 1 files changed

// File: rtl/xor_descrambler.sv
// Self-synchronizing x^7+x^4+1 descrambler with lock indication and beat counter.
// Latency: one cycle from input accept to registered output.
// Backpressure: in_ready_o = !out_valid_o || out_ready_i; output held stable while stalled.
module xor_descrambler #(
    parameter int DATA_W    = 8,
    parameter int LOCK_BITS = 7
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              resync_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              locked_o,
    output logic [15:0]       beat_cnt_o
);
    // Bit counter only needs to reach LOCK_BITS (max 255) plus one beat (max 64).
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_BITS);
    localparam logic [CNT_W-1:0] DATA_V = CNT_W'(DATA_W);

    logic [6:0]        sr_q, sr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic [15:0]       beat_q, beat_d;
    logic [CNT_W-1:0]  bits_q, bits_d;

    logic              accept;
    logic              xfer;
    logic [6:0]        sr_walk;
    logic [DATA_W-1:0] desc;
    logic [CNT_W-1:0]  bits_base;
    logic [CNT_W:0]    bits_sum;

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign xfer       = valid_q && out_ready_i;

    // Walk the beat bit by bit through the history; resync starts it from zero.
    always_comb begin
        sr_walk = resync_i ? 7'd0 : sr_q;
        desc    = '0;
        for (int k = 0; k < DATA_W; k++) begin
            desc[k] = in_data_i[k] ^ sr_walk[3] ^ sr_walk[6];
            sr_walk = {sr_walk[5:0], in_data_i[k]};
        end
    end

    // Next-state: history, lock counter, beat counter and output register.
    always_comb begin
        sr_d      = resync_i ? 7'd0 : sr_q;
        bits_base = resync_i ? '0 : bits_q;
        bits_d    = bits_base;
        bits_sum  = {1'b0, bits_base} + {1'b0, DATA_V};
        beat_d    = beat_q;
        data_d    = data_q;
        valid_d   = valid_q;
        if (accept) begin
            sr_d    = sr_walk;
            bits_d  = (bits_sum >= {1'b0, LOCK_V}) ? LOCK_V : bits_sum[CNT_W-1:0];
            beat_d  = beat_q + 16'd1;
            data_d  = desc;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        locked_d = resync_i ? 1'b0 : locked_q;
        if (bits_d >= LOCK_V) begin
            locked_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            beat_q   <= '0;
            bits_q   <= '0;
        end else begin
            sr_q     <= sr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            beat_q   <= beat_d;
            bits_q   <= bits_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign locked_o    = locked_q;
    assign beat_cnt_o  = beat_q;
endmodule
